// File: rtl/mem_region_router.sv
`default_nettype none
// ============================================================================
//  Module      : mem_region_router
//  Description : Decodes a single-outstanding master request into one of
//                NUM_REGIONS equal-sized slave regions, runs a registered
//                req/ack handshake with the selected slave, and returns read
//                data or an error response (unmapped address or slave
//                timeout). Keeps the most recent faulting address and a
//                saturating error count for the status block.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                m_req/m_we/m_addr/m_wdata, m_ready      - master request
//                m_resp_valid/m_rdata/m_error            - master response
//                s_sel/s_req/s_we/s_addr/s_wdata         - slave request
//                s_ack/s_rdata                           - slave response
//                err_clear/err_addr/err_count            - error record
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_region_router #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_REGIONS = 4,
    parameter int REGION_LSB  = 16,
    parameter int TIMEOUT     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          m_req,
    input  logic                          m_we,
    input  logic [ADDR_W-1:0]             m_addr,
    input  logic [DATA_W-1:0]             m_wdata,
    output logic                          m_ready,
    output logic                          m_resp_valid,
    output logic [DATA_W-1:0]             m_rdata,
    output logic                          m_error,
    output logic [NUM_REGIONS-1:0]        s_sel,
    output logic                          s_req,
    output logic                          s_we,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    input  logic [NUM_REGIONS-1:0]        s_ack,
    input  logic [NUM_REGIONS*DATA_W-1:0] s_rdata,
    input  logic                          err_clear,
    output logic [ADDR_W-1:0]             err_addr,
    output logic [7:0]                    err_count
);

    localparam int c_RGN_W = ADDR_W - REGION_LSB;
    localparam int c_CNT_W = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;

    logic [1:0]             r_state;
    logic [c_CNT_W-1:0]     r_tmo;
    logic                   r_ready;
    logic                   r_resp_valid;
    logic                   r_error;
    logic [DATA_W-1:0]      r_rdata;
    logic [NUM_REGIONS-1:0] r_s_sel;
    logic                   r_s_req;
    logic                   r_s_we;
    logic [ADDR_W-1:0]      r_s_addr;
    logic [DATA_W-1:0]      r_s_wdata;
    logic [ADDR_W-1:0]      r_err_addr;
    logic [7:0]             r_err_count;

    logic [c_RGN_W-1:0]     w_region;
    logic [NUM_REGIONS-1:0] w_dec_sel;
    logic                   w_mapped;
    logic                   w_ack;
    logic                   w_tmo_hit;
    logic [DATA_W-1:0]      w_sel_rdata;
    logic                   w_err_capture;
    logic [ADDR_W-1:0]      w_err_addr;

    assign w_region = m_addr[ADDR_W-1:REGION_LSB];

    // One-hot decode; an address whose region matches no slave is unmapped.
    always_comb begin
        w_dec_sel = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            w_dec_sel[i] = (w_region == c_RGN_W'(i));
        end
    end
    assign w_mapped = |w_dec_sel;

    // Only the selected slave's ack counts; the registered one-hot select
    // masks off spurious acks from the others.
    assign w_ack     = |(s_ack & r_s_sel);
    assign w_tmo_hit = (r_tmo == c_CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (r_s_sel[i]) begin
                w_sel_rdata = w_sel_rdata | s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Errors are recorded on the same edge the error response is decided.
    always_comb begin
        w_err_capture = 1'b0;
        w_err_addr    = r_s_addr;
        if (r_state == c_ST_IDLE && m_req && !w_mapped) begin
            w_err_capture = 1'b1;
            w_err_addr    = m_addr;
        end else if (r_state == c_ST_ACCESS && !w_ack && w_tmo_hit) begin
            w_err_capture = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_tmo        <= '0;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_error      <= 1'b0;
            r_rdata      <= '0;
            r_s_sel      <= '0;
            r_s_req      <= 1'b0;
            r_s_we       <= 1'b0;
            r_s_addr     <= '0;
            r_s_wdata    <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (m_req) begin
                        r_s_we    <= m_we;
                        r_s_addr  <= m_addr;
                        r_s_wdata <= m_wdata;
                        r_ready   <= 1'b0;
                        if (w_mapped) begin
                            r_state <= c_ST_ACCESS;
                            r_s_sel <= w_dec_sel;
                            r_s_req <= 1'b1;
                            r_tmo   <= '0;
                        end else begin
                            r_state      <= c_ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_error      <= 1'b1;
                            r_rdata      <= '0;
                        end
                    end
                end
                c_ST_ACCESS: begin
                    // Ack is checked before timeout so an ack on the last
                    // allowed cycle still completes cleanly.
                    if (w_ack) begin
                        r_state      <= c_ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_error      <= 1'b0;
                        r_rdata      <= r_s_we ? '0 : w_sel_rdata;
                        r_s_req      <= 1'b0;
                        r_s_sel      <= '0;
                    end else if (w_tmo_hit) begin
                        r_state      <= c_ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_error      <= 1'b1;
                        r_rdata      <= '0;
                        r_s_req      <= 1'b0;
                        r_s_sel      <= '0;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_ready <= 1'b1;
                    r_s_req <= 1'b0;
                    r_s_sel <= '0;
                end
            endcase
        end
    end

    // Error record: a capture coinciding with err_clear restarts the count at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_addr  <= '0;
            r_err_count <= '0;
        end else if (w_err_capture) begin
            r_err_addr <= w_err_addr;
            if (err_clear) begin
                r_err_count <= 8'd1;
            end else if (r_err_count != 8'hFF) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end else if (err_clear) begin
            r_err_addr  <= '0;
            r_err_count <= '0;
        end
    end

    assign m_ready      = r_ready;
    assign m_resp_valid = r_resp_valid;
    assign m_rdata      = r_rdata;
    assign m_error      = r_error;
    assign s_sel        = r_s_sel;
    assign s_req        = r_s_req;
    assign s_we         = r_s_we;
    assign s_addr       = r_s_addr;
    assign s_wdata      = r_s_wdata;
    assign err_addr     = r_err_addr;
    assign err_count    = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_region_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_region_router
//  Description : Self-checking bench for mem_region_router. A transaction-level
//                reference computes when the response must appear, its data
//                and error flag, and the error record, from the address map
//                and the slave's ack timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_region_router;

    localparam int c_TMO = 16;

    logic         clk;
    logic         reset;
    logic         m_req;
    logic         m_we;
    logic [31:0]  m_addr;
    logic [31:0]  m_wdata;
    logic         m_ready;
    logic         m_resp_valid;
    logic [31:0]  m_rdata;
    logic         m_error;
    logic [3:0]   s_sel;
    logic         s_req;
    logic         s_we;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_ack;
    logic [127:0] s_rdata;
    logic         err_clear;
    logic [31:0]  err_addr;
    logic [7:0]   err_count;

    int          n_chk;
    int          n_fail;
    int          exp_cnt;
    logic [31:0] exp_eaddr;

    mem_region_router #(
        .ADDR_W(32), .DATA_W(32), .NUM_REGIONS(4), .REGION_LSB(16), .TIMEOUT(c_TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_resp_valid(m_resp_valid), .m_rdata(m_rdata),
        .m_error(m_error), .s_sel(s_sel), .s_req(s_req), .s_we(s_we),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_ack(s_ack), .s_rdata(s_rdata),
        .err_clear(err_clear), .err_addr(err_addr), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish expected finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One master transaction. ack_at is the clock edge (counted from the
    // accept edge) at which the selected slave acks; 0 or > c_TMO = never.
    task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input int ack_at, input bit hold, input bit clr,
                       input logic [31:0] rd);
        int          idx;
        bit          mapped;
        bit          exp_err;
        int          resp_cyc;
        logic [31:0] exp_rd;
        logic [3:0]  one;
        idx    = int'(addr / 32'h1_0000);
        mapped = (idx < 4);
        one    = mapped ? 4'(1 << idx) : 4'b0;
        if (!mapped) begin
            resp_cyc = 1;
            exp_err  = 1'b1;
        end else if (ack_at >= 1 && ack_at <= c_TMO) begin
            resp_cyc = ack_at + 1;
            exp_err  = 1'b0;
        end else begin
            resp_cyc = c_TMO + 1;
            exp_err  = 1'b1;
        end
        exp_rd = (exp_err || we) ? 32'h0 : rd;

        chk("ready_before", m_ready, 1);
        m_req     = 1'b1;
        m_we      = we;
        m_addr    = addr;
        m_wdata   = wdata;
        err_clear = clr;
        s_rdata   = {$urandom, $urandom, $urandom, $urandom};
        if (mapped) s_rdata[idx*32 +: 32] = rd;
        tick();
        err_clear = 1'b0;
        if (!hold) begin
            m_req = 1'b0;
        end else begin
            m_we    = 1'($urandom);
            m_addr  = $urandom;
            m_wdata = $urandom;
        end

        for (int cyc = 1; cyc <= c_TMO + 1; cyc++) begin
            if (cyc == resp_cyc) begin
                chk("resp_valid", m_resp_valid, 1);
                chk("resp_error", m_error, exp_err);
                chk("resp_rdata", m_rdata, exp_rd);
                chk("resp_s_req", s_req, 0);
                chk("resp_s_sel", s_sel, 0);
                chk("resp_ready", m_ready, 0);
                s_ack = 4'($urandom);
                break;
            end
            chk("wait_no_resp", m_resp_valid, 0);
            chk("wait_s_req", s_req, 1);
            if (cyc == 1) begin
                chk("s_sel", s_sel, one);
                chk("s_we", s_we, we);
                chk("s_addr", s_addr, addr);
                chk("s_wdata", s_wdata, wdata);
                chk("busy_ready", m_ready, 0);
            end
            s_ack = 4'($urandom) & ~one;
            if (cyc == ack_at) s_ack = s_ack | one;
            tick();
            s_ack = 4'b0;
        end

        if (exp_err) begin
            exp_cnt   = clr ? 1 : ((exp_cnt == 255) ? 255 : exp_cnt + 1);
            exp_eaddr = addr;
        end else if (clr) begin
            exp_cnt   = 0;
            exp_eaddr = 32'h0;
        end
        chk("err_count", err_count, exp_cnt);
        chk("err_addr", err_addr, exp_eaddr);

        tick();
        s_ack = 4'b0;
        m_req = 1'b0;
        chk("after_resp_valid", m_resp_valid, 0);
        chk("after_resp_ready", m_ready, 1);
        chk("after_resp_s_req", s_req, 0);
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        exp_cnt   = 0;
        exp_eaddr = 32'h0;
        reset     = 1'b1;
        m_req     = 1'b0;
        m_we      = 1'b0;
        m_addr    = 32'h0;
        m_wdata   = 32'h0;
        s_ack     = 4'b0;
        s_rdata   = '0;
        err_clear = 1'b0;
        tick();
        tick();
        chk("rst_ready", m_ready, 1);
        chk("rst_resp_valid", m_resp_valid, 0);
        chk("rst_rdata", m_rdata, 0);
        chk("rst_error", m_error, 0);
        chk("rst_s_req", s_req, 0);
        chk("rst_s_sel", s_sel, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_err_addr", err_addr, 0);
        reset = 1'b0;
        tick();

        // Directed: read slave 1, write slave 3, unmapped, timeout, last-cycle ack.
        txn(1'b0, 32'h0001_0010, 32'h0, 1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        txn(1'b1, 32'h0003_0000, 32'hCAFE_F00D, 4, 1'b0, 1'b0, 32'h1234_5678);
        txn(1'b0, 32'h0004_0000, 32'h0, 1, 1'b0, 1'b0, 32'h0);
        txn(1'b0, 32'h0000_0000, 32'h0, 0, 1'b0, 1'b0, 32'h5555_AAAA);
        txn(1'b0, 32'h0000_0004, 32'h0, c_TMO, 1'b0, 1'b0, 32'h0BAD_CAFE);
        // m_req held through ACCESS and RESP must not start a second access.
        txn(1'b0, 32'h0002_0008, 32'h0, 3, 1'b1, 1'b0, 32'h7777_8888);

        // Reset in the middle of an access aborts it without a response.
        m_req  = 1'b1;
        m_we   = 1'b0;
        m_addr = 32'h0000_0100;
        tick();
        m_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        exp_cnt   = 0;
        exp_eaddr = 32'h0;
        chk("abort_s_req", s_req, 0);
        chk("abort_s_sel", s_sel, 0);
        chk("abort_ready", m_ready, 1);
        chk("abort_err_count", err_count, 0);
        s_ack = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_resp", m_resp_valid, 0);
            chk("abort_idle_s_req", s_req, 0);
        end
        s_ack = 4'b0;

        // Randomized mix of mapped, unmapped, timed-out and held requests.
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a;
            a = {16'($urandom_range(0, 5)), 16'($urandom)};
            txn(1'($urandom), a, $urandom, $urandom_range(1, c_TMO + 2),
                1'($urandom), 1'b0, $urandom);
        end

        // Saturation of the error counter.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = {16'($urandom_range(4, 16'hFFFF)), 16'($urandom)};
            txn(1'($urandom), a, $urandom, 1, 1'b0, 1'b0, 32'h0);
        end
        chk("saturated", err_count, 255);

        // Clear coincident with an error capture: capture wins with count 1.
        txn(1'b0, 32'h0009_0040, 32'h0, 1, 1'b0, 1'b1, 32'h0);
        txn(1'b0, 32'h000A_0044, 32'h0, 1, 1'b0, 1'b0, 32'h0);
        chk("count_after_clr_capture", err_count, 2);

        // Clear on its own.
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        exp_cnt   = 0;
        exp_eaddr = 32'h0;
        chk("clear_count", err_count, exp_cnt);
        chk("clear_addr", err_addr, exp_eaddr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
